// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control bundle between the multicycle controller and its datapath
interface mc_ctrl_if;
    logic [5:0]  OPCode;
    logic [5:0]  Funct;
    logic        Zero;
    logic        PCWrite;
    logic        IRWrite;
    logic [1:0]  RegDst;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemWrite;
    logic [1:0]  MemToReg;
    logic        ExtOp;
    logic [1:0]  nPC_sel;
    logic [2:0]  ALUCtrl;
    logic [2:0]  state;
    logic        instr_done;
    logic [31:0] retired;

    modport master (
        input  OPCode, Funct, Zero,
        output PCWrite, IRWrite, RegDst, ALUSrc, RegWrite, MemWrite,
        output MemToReg, ExtOp, nPC_sel, ALUCtrl, state, instr_done, retired
    );

    modport slave (
        output OPCode, Funct, Zero,
        input  PCWrite, IRWrite, RegDst, ALUSrc, RegWrite, MemWrite,
        input  MemToReg, ExtOp, nPC_sel, ALUCtrl, state, instr_done, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset controller FSM with retired-instruction counter
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    mc_ctrl_if.master  bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J, C_JAL
    } cls_t;

    logic [2:0]  state_q, state_d;
    cls_t        dec_cls, cls_q;
    logic [31:0] retired_q;
    logic        done;

    logic        pc_write, ir_write, alu_src, reg_write, mem_write, ext_op;
    logic [1:0]  reg_dst, mem_to_reg, npc_sel;
    logic [2:0]  alu_ctrl;

    // classify the instruction currently presented by the IR
    always_comb begin
        dec_cls = C_NOP;
        case (bus.OPCode)
            6'b000000: begin
                case (bus.Funct)
                    6'b100001: dec_cls = C_ADDU;
                    6'b100011: dec_cls = C_SUBU;
                    6'b001000: dec_cls = C_JR;
                    default:   dec_cls = C_NOP;
                endcase
            end
            6'b001101: dec_cls = C_ORI;
            6'b100011: dec_cls = C_LW;
            6'b101011: dec_cls = C_SW;
            6'b000100: dec_cls = C_BEQ;
            6'b001111: dec_cls = C_LUI;
            6'b000010: dec_cls = C_J;
            6'b000011: dec_cls = C_JAL;
            default:   dec_cls = C_NOP;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // capture the class in DECODE so later states ignore IR changes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_q <= C_NOP;
        end else if (state_q == S_DECODE) begin
            cls_q <= dec_cls;
        end
    end

    // count instructions on their final edge; wraps naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= 32'd0;
        end else if (done) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    // next-state selection
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (dec_cls)
                    C_J, C_JR, C_NOP: state_d = S_FETCH;
                    C_JAL:            state_d = S_WB;
                    default:          state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
                    C_LW, C_SW:                   state_d = S_MEM;
                    default:                      state_d = S_FETCH;
                endcase
            end
            S_MEM:    state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    assign done = (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM ||
                   state_q == S_WB) && (state_d == S_FETCH);

    // per-state control outputs; anything not driven stays 0
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        ext_op     = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        npc_sel    = 2'b00;
        alu_ctrl   = 3'b000;
        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                if (dec_cls == C_J) begin
                    pc_write = 1'b1;
                    npc_sel  = 2'b10;
                end else if (dec_cls == C_JR) begin
                    pc_write = 1'b1;
                    npc_sel  = 2'b11;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_SUBU: alu_ctrl = 3'b001;
                    C_ORI: begin
                        alu_src  = 1'b1;
                        alu_ctrl = 3'b010;
                    end
                    C_LUI: begin
                        alu_src  = 1'b1;
                        alu_ctrl = 3'b011;
                    end
                    C_LW, C_SW: begin
                        alu_src = 1'b1;
                        ext_op  = 1'b1;
                    end
                    C_BEQ: begin
                        alu_ctrl = 3'b001;
                        npc_sel  = 2'b01;
                        pc_write = bus.Zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                alu_src   = 1'b1;
                ext_op    = 1'b1;
                mem_write = (cls_q == C_SW);
            end
            S_WB: begin
                case (cls_q)
                    C_ADDU, C_SUBU: begin
                        reg_write = 1'b1;
                        reg_dst   = 2'b01;
                    end
                    C_ORI, C_LUI: reg_write = 1'b1;
                    C_LW: begin
                        reg_write  = 1'b1;
                        mem_to_reg = 2'b01;
                    end
                    C_JAL: begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                        pc_write   = 1'b1;
                        npc_sel    = 2'b10;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // reset masks every strobe at once so an aborted instruction writes nothing
    assign bus.PCWrite    = pc_write  & ~reset;
    assign bus.IRWrite    = ir_write  & ~reset;
    assign bus.ALUSrc     = alu_src   & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.ExtOp      = ext_op    & ~reset;
    assign bus.RegDst     = reset ? 2'b00  : reg_dst;
    assign bus.MemToReg   = reset ? 2'b00  : mem_to_reg;
    assign bus.nPC_sel    = reset ? 2'b00  : npc_sel;
    assign bus.ALUCtrl    = reset ? 3'b000 : alu_ctrl;
    assign bus.state      = state_q;
    assign bus.instr_done = done & ~reset;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard testbench for mc_ctrl
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic reset;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // field order: state, PCWrite, IRWrite, RegDst, ALUSrc, RegWrite, MemWrite, MemToReg, ExtOp, nPC_sel, ALUCtrl, instr_done
    localparam logic [18:0] F_V    = 19'b000_1_1_00_0_0_0_00_0_00_000_0;
    localparam logic [18:0] D_V    = 19'b001_0_0_00_0_0_0_00_0_00_000_0;
    localparam logic [18:0] DN_V   = 19'b001_0_0_00_0_0_0_00_0_00_000_1;
    localparam logic [18:0] DJ_V   = 19'b001_1_0_00_0_0_0_00_0_10_000_1;
    localparam logic [18:0] DJR_V  = 19'b001_1_0_00_0_0_0_00_0_11_000_1;
    localparam logic [18:0] EADD_V = 19'b010_0_0_00_0_0_0_00_0_00_000_0;
    localparam logic [18:0] ESUB_V = 19'b010_0_0_00_0_0_0_00_0_00_001_0;
    localparam logic [18:0] EORI_V = 19'b010_0_0_00_1_0_0_00_0_00_010_0;
    localparam logic [18:0] ELUI_V = 19'b010_0_0_00_1_0_0_00_0_00_011_0;
    localparam logic [18:0] EMEM_V = 19'b010_0_0_00_1_0_0_00_1_00_000_0;
    localparam logic [18:0] EBQ1_V = 19'b010_1_0_00_0_0_0_00_0_01_001_1;
    localparam logic [18:0] EBQ0_V = 19'b010_0_0_00_0_0_0_00_0_01_001_1;
    localparam logic [18:0] MLW_V  = 19'b011_0_0_00_1_0_0_00_1_00_000_0;
    localparam logic [18:0] MSW_V  = 19'b011_0_0_00_1_0_1_00_1_00_000_1;
    localparam logic [18:0] WR_V   = 19'b100_0_0_01_0_1_0_00_0_00_000_1;
    localparam logic [18:0] WI_V   = 19'b100_0_0_00_0_1_0_00_0_00_000_1;
    localparam logic [18:0] WLW_V  = 19'b100_0_0_00_0_1_0_01_0_00_000_1;
    localparam logic [18:0] WJAL_V = 19'b100_1_0_10_0_1_0_10_0_10_000_1;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [18:0] ctl;
        logic [31:0] ret;
    } cyc_t;

    cyc_t        sb_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_retired = 32'd0;
    logic [18:0] obs_v;

    assign obs_v = {bus.state, bus.PCWrite, bus.IRWrite, bus.RegDst, bus.ALUSrc, bus.RegWrite,
                    bus.MemWrite, bus.MemToReg, bus.ExtOp, bus.nPC_sel, bus.ALUCtrl, bus.instr_done};

    // queue one cycle of stimulus with its expected controls and counter value
    task automatic push(input logic [5:0] op, input logic [5:0] funct, input logic z,
                        input logic [18:0] ctl);
        cyc_t c;
        c.op = op; c.funct = funct; c.zero = z; c.ctl = ctl; c.ret = exp_retired;
        sb_q.push_back(c);
        if (ctl[0]) exp_retired = exp_retired + 32'd1;
    endtask

    task automatic test_reset();
        bus.OPCode = 6'd0; bus.Funct = 6'd0; bus.Zero = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        tests_run++;
        if (bus.state !== 3'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", bus.state); end
        tests_run++;
        if (bus.instr_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus.instr_done); end
        tests_run++;
        if (bus.retired !== 32'd0) begin tests_failed++; $display("FAIL reset_retired got %h want 0", bus.retired); end
        tests_run++;
        if ({bus.PCWrite, bus.RegWrite, bus.MemWrite} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_strobes got %b want 000", {bus.PCWrite, bus.RegWrite, bus.MemWrite});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_retired = 32'd0;
    endtask

    task automatic test_rtype();
        cyc_t c;
        int n = 0;
        push(6'd0, 6'h21, 1'b0, F_V); push(6'd0, 6'h21, 1'b0, D_V);
        push(6'h3f, 6'h08, 1'b1, EADD_V); push(6'h3f, 6'h08, 1'b1, WR_V);
        push(6'd0, 6'h23, 1'b0, F_V); push(6'd0, 6'h23, 1'b0, D_V);
        push(6'd0, 6'h23, 1'b0, ESUB_V); push(6'd0, 6'h23, 1'b0, WR_V);
        while (sb_q.size() != 0) begin
            c = sb_q.pop_front();
            bus.OPCode = c.op; bus.Funct = c.funct; bus.Zero = c.zero;
            #1;
            tests_run++;
            if (obs_v !== c.ctl) begin tests_failed++; $display("FAIL rtype ctl cyc %0d got %b want %b", n, obs_v, c.ctl); end
            tests_run++;
            if (bus.retired !== c.ret) begin tests_failed++; $display("FAIL rtype retired cyc %0d got %h want %h", n, bus.retired, c.ret); end
            n++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (bus.retired !== exp_retired) begin tests_failed++; $display("FAIL rtype retired_end got %h want %h", bus.retired, exp_retired); end
    endtask

    task automatic test_itype_mem();
        cyc_t c;
        int n = 0;
        push(6'h0d, 6'd0, 1'b0, F_V); push(6'h0d, 6'd0, 1'b0, D_V);
        push(6'h0d, 6'd0, 1'b0, EORI_V); push(6'h0d, 6'd0, 1'b0, WI_V);
        push(6'h0f, 6'd0, 1'b0, F_V); push(6'h0f, 6'd0, 1'b0, D_V);
        push(6'h0f, 6'd0, 1'b0, ELUI_V); push(6'h0f, 6'd0, 1'b0, WI_V);
        push(6'h23, 6'd0, 1'b0, F_V); push(6'h23, 6'd0, 1'b0, D_V);
        push(6'h23, 6'd0, 1'b0, EMEM_V); push(6'h23, 6'd0, 1'b0, MLW_V); push(6'h23, 6'd0, 1'b0, WLW_V);
        push(6'h2b, 6'd0, 1'b0, F_V); push(6'h2b, 6'd0, 1'b0, D_V);
        push(6'h2b, 6'd0, 1'b0, EMEM_V); push(6'h2b, 6'd0, 1'b0, MSW_V);
        while (sb_q.size() != 0) begin
            c = sb_q.pop_front();
            bus.OPCode = c.op; bus.Funct = c.funct; bus.Zero = c.zero;
            #1;
            tests_run++;
            if (obs_v !== c.ctl) begin tests_failed++; $display("FAIL imem ctl cyc %0d got %b want %b", n, obs_v, c.ctl); end
            tests_run++;
            if (bus.retired !== c.ret) begin tests_failed++; $display("FAIL imem retired cyc %0d got %h want %h", n, bus.retired, c.ret); end
            n++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (bus.retired !== exp_retired) begin tests_failed++; $display("FAIL imem retired_end got %h want %h", bus.retired, exp_retired); end
    endtask

    task automatic test_branch_jump();
        cyc_t c;
        int n = 0;
        push(6'h04, 6'd0, 1'b1, F_V); push(6'h04, 6'd0, 1'b1, D_V); push(6'h04, 6'd0, 1'b1, EBQ1_V);
        push(6'h04, 6'd0, 1'b1, F_V); push(6'h04, 6'd0, 1'b1, D_V); push(6'h04, 6'd0, 1'b0, EBQ0_V);
        push(6'h02, 6'd0, 1'b1, F_V); push(6'h02, 6'd0, 1'b1, DJ_V);
        push(6'd0, 6'h08, 1'b1, F_V); push(6'd0, 6'h08, 1'b1, DJR_V);
        push(6'h03, 6'd0, 1'b1, F_V); push(6'h03, 6'd0, 1'b1, D_V); push(6'h03, 6'd0, 1'b1, WJAL_V);
        while (sb_q.size() != 0) begin
            c = sb_q.pop_front();
            bus.OPCode = c.op; bus.Funct = c.funct; bus.Zero = c.zero;
            #1;
            tests_run++;
            if (obs_v !== c.ctl) begin tests_failed++; $display("FAIL brj ctl cyc %0d got %b want %b", n, obs_v, c.ctl); end
            tests_run++;
            if (bus.retired !== c.ret) begin tests_failed++; $display("FAIL brj retired cyc %0d got %h want %h", n, bus.retired, c.ret); end
            n++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (bus.retired !== exp_retired) begin tests_failed++; $display("FAIL brj retired_end got %h want %h", bus.retired, exp_retired); end
    endtask

    task automatic test_nop_wrap();
        cyc_t c;
        int n = 0;
        push(6'h3f, 6'd0, 1'b0, F_V); push(6'h3f, 6'd0, 1'b0, DN_V);
        push(6'd0, 6'h3f, 1'b0, F_V); push(6'd0, 6'h3f, 1'b0, DN_V);
        while (sb_q.size() != 0) begin
            c = sb_q.pop_front();
            bus.OPCode = c.op; bus.Funct = c.funct; bus.Zero = c.zero;
            #1;
            tests_run++;
            if (obs_v !== c.ctl) begin tests_failed++; $display("FAIL nop ctl cyc %0d got %b want %b", n, obs_v, c.ctl); end
            tests_run++;
            if (bus.retired !== c.ret) begin tests_failed++; $display("FAIL nop retired cyc %0d got %h want %h", n, bus.retired, c.ret); end
            n++;
            @(posedge clk); #1;
        end
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        exp_retired = 32'hFFFF_FFFF;
        push(6'h3f, 6'h3f, 1'b0, F_V); push(6'h3f, 6'h3f, 1'b0, DN_V);
        while (sb_q.size() != 0) begin
            c = sb_q.pop_front();
            bus.OPCode = c.op; bus.Funct = c.funct; bus.Zero = c.zero;
            #1;
            tests_run++;
            if (obs_v !== c.ctl) begin tests_failed++; $display("FAIL wrap ctl cyc %0d got %b want %b", n, obs_v, c.ctl); end
            tests_run++;
            if (bus.retired !== c.ret) begin tests_failed++; $display("FAIL wrap retired cyc %0d got %h want %h", n, bus.retired, c.ret); end
            n++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (bus.retired !== 32'd0) begin tests_failed++; $display("FAIL wrap retired_end got %h want 00000000", bus.retired); end
    endtask

    task automatic test_reset_mid();
        cyc_t c;
        int n = 0;
        push(6'h2b, 6'd0, 1'b0, F_V); push(6'h2b, 6'd0, 1'b0, D_V); push(6'h2b, 6'd0, 1'b0, EMEM_V);
        while (sb_q.size() != 0) begin
            c = sb_q.pop_front();
            bus.OPCode = c.op; bus.Funct = c.funct; bus.Zero = c.zero;
            #1;
            tests_run++;
            if (obs_v !== c.ctl) begin tests_failed++; $display("FAIL rstmid ctl cyc %0d got %b want %b", n, obs_v, c.ctl); end
            n++;
            @(posedge clk); #1;
        end
        #1;
        tests_run++;
        if (bus.MemWrite !== 1'b1) begin tests_failed++; $display("FAIL rstmid pre_memwrite got %b want 1", bus.MemWrite); end
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.MemWrite !== 1'b0) begin tests_failed++; $display("FAIL rstmid memwrite got %b want 0", bus.MemWrite); end
        tests_run++;
        if (bus.state !== 3'd0) begin tests_failed++; $display("FAIL rstmid state got %0d want 0", bus.state); end
        tests_run++;
        if (bus.retired !== 32'd0) begin tests_failed++; $display("FAIL rstmid retired got %h want 0", bus.retired); end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_retired = 32'd0;
        push(6'd0, 6'h21, 1'b0, F_V); push(6'd0, 6'h21, 1'b0, D_V);
        push(6'd0, 6'h21, 1'b0, EADD_V); push(6'd0, 6'h21, 1'b0, WR_V);
        while (sb_q.size() != 0) begin
            c = sb_q.pop_front();
            bus.OPCode = c.op; bus.Funct = c.funct; bus.Zero = c.zero;
            #1;
            tests_run++;
            if (obs_v !== c.ctl) begin tests_failed++; $display("FAIL recover ctl cyc %0d got %b want %b", n, obs_v, c.ctl); end
            tests_run++;
            if (bus.retired !== c.ret) begin tests_failed++; $display("FAIL recover retired cyc %0d got %h want %h", n, bus.retired, c.ret); end
            n++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (bus.retired !== 32'd1) begin tests_failed++; $display("FAIL recover retired_end got %h want 00000001", bus.retired); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype_mem();
        test_branch_jump();
        test_nop_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have: OPCode  in  6  IR[31:26] from datapath; Funct  in  6  IR[5:0]; Zero  in  1  ALU equality flag.
REQ-004 SHALL have outputs: PCWrite 1; IRWrite 1; RegDst 2 (00 rt, 01 rd, 10 $31); ALUSrc 1 (0 reg, 1 ext imm); RegWrite 1; MemWrite 1.
REQ-005 SHALL have outputs: MemToReg 2 (00 ALU, 01 mem data, 10 PC+4); ExtOp 1 (1 sign, 0 zero); nPC_sel 2 (00 PC+4, 01 branch, 10 j-target, 11 rs); ALUCtrl 3 (000 add, 001 sub, 010 or, 011 lui).
REQ-006 SHALL have outputs: state 3 (current FSM state); instr_done 1 (one-cycle pulse on an instruction's final cycle); retired 32 (retired-instruction count).

Function
REQ-007 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge with all outputs 0.
REQ-008 SHALL decode classes: RTYPE (op 000000, funct 100001 addu / 100011 subu), JR (op 000000, funct 001000), ORI 001101, LW 100011, SW 101011, BEQ 000100, LUI 001111, J 000010, JAL 000011; everything else is NOP.
REQ-009 SHALL latch the decoded class into an internal register in DECODE; EXEC/MEM/WB outputs SHALL derive from state plus latched class only.
REQ-010 FETCH: IRWrite=1, PCWrite=1, nPC_sel=00; next DECODE.
REQ-011 DECODE: J -> PCWrite=1, nPC_sel=10, next FETCH; JR -> PCWrite=1, nPC_sel=11, next FETCH; NOP -> next FETCH; JAL -> next WB; all other classes -> next EXEC.
REQ-012 EXEC: RTYPE -> ALUSrc=0, ALUCtrl 000 (addu) or 001 (subu), next WB; ORI -> ALUSrc=1, ExtOp=0, ALUCtrl=010, next WB; LUI -> ALUSrc=1, ALUCtrl=011, next WB.
REQ-013 EXEC: LW/SW -> ALUSrc=1, ExtOp=1, ALUCtrl=000, next MEM; BEQ -> ALUSrc=0, ALUCtrl=001, nPC_sel=01, PCWrite=Zero, next FETCH.
REQ-014 MEM: SW -> MemWrite=1, next FETCH; LW -> next WB; address controls held as in EXEC.
REQ-015 WB: RegWrite=1, next FETCH. RTYPE: RegDst=01, MemToReg=00. ORI/LUI: RegDst=00, MemToReg=00. LW: RegDst=00, MemToReg=01. JAL: RegDst=10, MemToReg=10, PCWrite=1, nPC_sel=10.
REQ-016 Any output not listed for a state/class SHALL be 0; RegWrite and MemWrite SHALL never both be 1.
REQ-017 Latency in cycles, FETCH through last state: RTYPE/ORI/LUI 4, LW 5, SW 4, BEQ 3, J/JR/NOP 2, JAL 3.
REQ-018 instr_done SHALL be 1 exactly in the cycle whose next state is FETCH (the DECODE/EXEC/MEM/WB state), and 0 in FETCH.
REQ-019 retired SHALL increment by 1 on each edge where instr_done=1, including NOP; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-020 Zero SHALL be sampled only in EXEC for BEQ; in all other states it SHALL be ignored.

Reset
REQ-021 While reset=1: state=FETCH, latched class=NOP, retired=0, instr_done=0.
REQ-022 Reset asserted mid-instruction (any state) SHALL abort it with no further PCWrite/RegWrite/MemWrite, and SHALL NOT count it as retired.
REQ-023 After reset deasserts, the first rising edge SHALL perform FETCH, with IRWrite=1 and PCWrite=1 visible combinationally in that cycle.

Verification
REQ-024 addu (op 0, funct 100001) after reset -> states 0,1,2,4; RegWrite=1 only in WB with RegDst=01; retired=1 after 4 edges.
REQ-025 lw (op 100011) -> states 0,1,2,3,4; MemToReg=01 in WB; sw (op 101011) -> MemWrite=1 only in MEM, RegWrite never 1.
REQ-026 beq with Zero=1 -> PCWrite=1, nPC_sel=01 in EXEC; repeat with Zero=0 -> PCWrite=0 in EXEC; both take 3 cycles.
REQ-027 jal -> states 0,1,4; WB drives RegDst=10, MemToReg=10, PCWrite=1, nPC_sel=10. jr -> PCWrite=1, nPC_sel=11 in DECODE.
REQ-028 Unknown op 111111 -> 2 cycles, no write strobes, retired increments. Preload retired=0xFFFFFFFF via a run of NOPs or a force, then one NOP -> retired=0.
REQ-029 Assert reset during MEM of sw -> MemWrite drops to 0 immediately, state=0, retired=0.
